// File: rtl/pwm_counter_if.sv
// Control and status bundle for the PWM time-base counter.
// The master drives the controls and the slave returns the count and wrap strobe.
interface pwm_counter_if;
  logic        en;
  logic        count_reset;
  logic        dir;
  logic [7:0]  prescale;
  logic [15:0] period;
  logic [15:0] count_val;
  logic        wrap_pulse;

  modport master (
    output en, count_reset, dir, prescale, period,
    input  count_val, wrap_pulse
  );

  modport slave (
    input  en, count_reset, dir, prescale, period,
    output count_val, wrap_pulse
  );
endinterface

// File: rtl/pwm_counter.sv
// Prescaled up/down PWM time-base counter with a registered wrap strobe.
// Period, prescale and direction are shadowed and take effect only at wrap, restart or while disabled.
module pwm_counter (
  input  logic         clk,
  input  logic         rst_n,
  pwm_counter_if.slave bus
);

  logic [15:0] prd_a;
  logic [7:0]  psc_a;
  logic        dir_a;
  logic [7:0]  psc_cnt;
  logic [15:0] count_val;
  logic        wrap_pulse;

  logic        tick;
  logic        at_terminal;
  logic [15:0] count_step;
  logic        load;

  // Next count on a tick, and whether that tick ends the period.
  always_comb begin
    tick        = bus.en && (psc_cnt == psc_a);
    at_terminal = 1'b0;
    count_step  = count_val;
    if (dir_a) begin
      if (count_val == 16'd0) begin
        count_step  = prd_a;
        at_terminal = 1'b1;
      end else begin
        count_step = count_val - 16'd1;
      end
    end else begin
      if (count_val >= prd_a) begin
        count_step  = 16'd0;
        at_terminal = 1'b1;
      end else begin
        count_step = count_val + 16'd1;
      end
    end
    load = bus.count_reset || !bus.en || (tick && at_terminal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prd_a      <= 16'd0;
      psc_a      <= 8'd0;
      dir_a      <= 1'b0;
      psc_cnt    <= 8'd0;
      count_val  <= 16'd0;
      wrap_pulse <= 1'b0;
    end else begin
      if (load) begin
        prd_a <= bus.period;
        psc_a <= bus.prescale;
        dir_a <= bus.dir;
      end
      // Restart wins over everything and seeds the count from the incoming direction.
      if (bus.count_reset) begin
        psc_cnt    <= 8'd0;
        count_val  <= bus.dir ? bus.period : 16'd0;
        wrap_pulse <= 1'b0;
      end else if (!bus.en) begin
        psc_cnt    <= 8'd0;
        wrap_pulse <= 1'b0;
      end else if (tick) begin
        psc_cnt    <= 8'd0;
        count_val  <= count_step;
        wrap_pulse <= at_terminal;
      end else begin
        psc_cnt    <= psc_cnt + 8'd1;
        wrap_pulse <= 1'b0;
      end
    end
  end

  assign bus.count_val  = count_val;
  assign bus.wrap_pulse = wrap_pulse;

endmodule

// File: tb/tb_pwm_counter.sv
// Bench for pwm_counter: directed scenarios plus randomized traffic against a tick/period reference model.
module tb_pwm_counter;

  logic clk;
  logic rst_n;
  pwm_counter_if bus ();

  pwm_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Reference model: active settings plus cycles still to wait before the next tick.
  int m_count;
  int m_wrap;
  int m_prd;
  int m_psc;
  int m_dir;
  int m_wait;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cr, input logic dir,
                               input logic [7:0] ps, input logic [15:0] pr);
    bus.en          = en;
    bus.count_reset = cr;
    bus.dir         = dir;
    bus.prescale    = ps;
    bus.period      = pr;
  endtask

  task automatic modelReset();
    m_count = 0; m_wrap = 0; m_prd = 0; m_psc = 0; m_dir = 0; m_wait = 0;
  endtask

  task automatic modelLoad();
    m_prd = int'(bus.period);
    m_psc = int'(bus.prescale);
    m_dir = int'(bus.dir);
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
    end else if (bus.count_reset) begin
      modelLoad();
      m_count = (m_dir != 0) ? m_prd : 0;
      m_wrap  = 0;
      m_wait  = m_psc;
    end else if (!bus.en) begin
      modelLoad();
      m_wrap = 0;
      m_wait = m_psc;
    end else if (m_wait == 0) begin
      m_wrap = 0;
      if (m_dir == 0) begin
        if (m_count >= m_prd) begin m_count = 0; m_wrap = 1; end
        else m_count = m_count + 1;
      end else begin
        if (m_count == 0) begin m_count = m_prd; m_wrap = 1; end
        else m_count = m_count - 1;
      end
      if (m_wrap != 0) modelLoad();
      m_wait = m_psc;
    end else begin
      m_wait = m_wait - 1;
      m_wrap = 0;
    end
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput({tag, ".count"}, int'(bus.count_val), m_count);
    checkOutput({tag, ".wrap"}, int'(bus.wrap_pulse), m_wrap);
  endtask

  task automatic asyncReset(input string tag);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput({tag, ".rst_count"}, int'(bus.count_val), 0);
    checkOutput({tag, ".rst_wrap"}, int'(bus.wrap_pulse), 0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_v;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    modelReset();
    #12;
    checkOutput("reset.count", int'(bus.count_val), 0);
    checkOutput("reset.wrap", int'(bus.wrap_pulse), 0);
    #5;
    rst_n = 1'b1;

    $display("[TB] up count, period 4, no prescale");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 16'd4);
    stepCycle("up4.load");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd4);
    for (int i = 0; i < 12; i++) begin
      stepCycle("up4");
      exp_v = (i + 1) % 5;
      checkOutput("up4.seq", int'(bus.count_val), exp_v);
      checkOutput("up4.seq_wrap", int'(bus.wrap_pulse), (exp_v == 0) ? 1 : 0);
    end

    $display("[TB] down count, period 3, prescale 2");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd2, 16'd3);
    stepCycle("down3.restart");
    checkOutput("down3.restart_val", int'(bus.count_val), 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 16'd3);
    for (int k = 1; k <= 24; k++) begin
      stepCycle("down3");
      checkOutput("down3.seq", int'(bus.count_val), 3 - ((k / 3) % 4));
      checkOutput("down3.seq_wrap", int'(bus.wrap_pulse), (k % 12 == 0) ? 1 : 0);
    end

    $display("[TB] period change mid-period");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 16'd9);
    stepCycle("prd.restart");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd9);
    stepCycle("prd.run");
    stepCycle("prd.run");
    checkOutput("prd.at2", int'(bus.count_val), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd5);
    for (int i = 0; i < 7; i++) stepCycle("prd.old");
    checkOutput("prd.reach9", int'(bus.count_val), 9);
    stepCycle("prd.wrap1");
    checkOutput("prd.wrap1_val", int'(bus.count_val), 0);
    checkOutput("prd.wrap1_pulse", int'(bus.wrap_pulse), 1);
    for (int i = 0; i < 5; i++) stepCycle("prd.new");
    checkOutput("prd.reach5", int'(bus.count_val), 5);
    stepCycle("prd.wrap2");
    checkOutput("prd.wrap2_val", int'(bus.count_val), 0);
    checkOutput("prd.wrap2_pulse", int'(bus.wrap_pulse), 1);

    $display("[TB] enable drop and resume");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd1, 16'd9);
    stepCycle("en.restart");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 16'd9);
    for (int i = 0; i < 12; i++) stepCycle("en.run");
    checkOutput("en.at6", int'(bus.count_val), 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 16'd9);
    for (int i = 0; i < 10; i++) begin
      stepCycle("en.off");
      checkOutput("en.hold", int'(bus.count_val), 6);
      checkOutput("en.hold_wrap", int'(bus.wrap_pulse), 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd1, 16'd9);
    stepCycle("en.resume");
    checkOutput("en.resume_wait", int'(bus.count_val), 6);
    stepCycle("en.resume");
    checkOutput("en.resume_7", int'(bus.count_val), 7);

    $display("[TB] count_reset into down mode");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, 16'h00FF);
    stepCycle("cr");
    checkOutput("cr.val", int'(bus.count_val), 255);
    checkOutput("cr.wrap", int'(bus.wrap_pulse), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, 16'h00FF);
    for (int i = 0; i < 3; i++) stepCycle("cr.run");

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 16'd9);
    asyncReset("arst");
    stepCycle("arst.restart");
    checkOutput("arst.first", int'(bus.count_val), 0);
    stepCycle("arst.restart");
    checkOutput("arst.second", int'(bus.count_val), 1);

    $display("[TB] maximum prescale");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd255, 16'd3);
    stepCycle("psc255.restart");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd255, 16'd3);
    for (int i = 0; i < 255; i++) stepCycle("psc255");
    checkOutput("psc255.before", int'(bus.count_val), 0);
    stepCycle("psc255");
    checkOutput("psc255.tick", int'(bus.count_val), 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      logic       r_en;
      logic       r_dir;
      logic [7:0] r_ps;
      logic [15:0] r_pr;
      r_en  = bus.en;
      r_dir = bus.dir;
      r_ps  = bus.prescale;
      r_pr  = bus.period;
      if ($urandom_range(0, 5) == 0) begin
        r_en  = ($urandom_range(0, 7) != 0);
        r_dir = 1'($urandom_range(0, 1));
        r_ps  = 8'($urandom_range(0, 3));
        r_pr  = 16'($urandom_range(0, 12));
      end
      applyStimulus(r_en, ($urandom_range(0, 29) == 0), r_dir, r_ps, r_pr);
      if ($urandom_range(0, 199) == 0) asyncReset("rand");
      stepCycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/pwm_counter.md
PWM_COUNTER -- requirements
Module: pwm_counter

Interface
REQ-001 The block SHALL provide `clk`, input, 1 bit: the clock; all state updates on its rising edge.
REQ-002 The block SHALL provide `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide `en`, input, 1 bit: counting enable (1 = run, 0 = freeze).
REQ-004 The block SHALL provide `count_reset`, input, 1 bit: synchronous restart strobe, active high.
REQ-005 The block SHALL provide `dir`, input, 1 bit: count direction (0 = up, 1 = down).
REQ-006 The block SHALL provide `prescale`, input, 8 bits: count advances every `prescale`+1 clk cycles.
REQ-007 The block SHALL provide `period`, input, 16 bits: terminal count value.
REQ-008 The block SHALL provide `count_val`, output, 16 bits: registered counter value feeding the PWM comparator.
REQ-009 The block SHALL provide `wrap_pulse`, output, 1 bit: registered single-cycle strobe on each period wrap.

Function
REQ-010 The block SHALL hold internal active copies `prd_a` (16b), `psc_a` (8b) and `dir_a` (1b).
- Load sources: `period`, `prescale`, `dir`.
- Load times: a wrap cycle, a `count_reset` cycle, or any cycle with `en`=0.
- No other changes to the active copies.
REQ-011 The block SHALL keep an 8-bit prescaler counter `psc_cnt` and generate an internal tick when `en`=1 and `psc_cnt`==`psc_a`.
- On a tick, `psc_cnt` returns to 0.
- Otherwise, with `en`=1, `psc_cnt` increments.
REQ-012 With `psc_a`=0, the block SHALL tick every enabled clk cycle; with `psc_a`=255, every 256 cycles.
REQ-013 Up mode (`dir_a`=0), on a tick: if `count_val` >= `prd_a`, the block SHALL load 0 and assert a wrap; otherwise it SHALL increment `count_val` by 1.
REQ-014 Down mode (`dir_a`=1), on a tick: if `count_val`==0, the block SHALL load `prd_a` and assert a wrap; otherwise it SHALL decrement `count_val` by 1.
REQ-015 One period SHALL be `prd_a`+1 ticks in both directions; the arithmetic is 16-bit unsigned and never wraps through 0xFFFF/0x0000 outside REQ-013/REQ-014.
REQ-016 `wrap_pulse` SHALL be 1 in exactly the clk cycle in which `count_val` shows the wrap value, and 0 in every other cycle.
REQ-017 With `prd_a`=0, `count_val` SHALL stay 0 and `wrap_pulse` SHALL assert on every tick.
REQ-018 With `en`=0, the block SHALL:
- hold `count_val`;
- clear `psc_cnt` to 0;
- drive `wrap_pulse`=0.
REQ-019 On re-enable, the first tick SHALL occur `psc_a`+1 cycles after `en` rises.
- If the held `count_val` exceeds the new `prd_a` in up mode, that first tick wraps to 0 per REQ-013.
REQ-020 `count_reset`=1 SHALL override tick and enable, and in the next cycle produce:
- `psc_cnt`=0;
- `count_val`=0 if the newly loaded `dir` is 0, else `count_val`=the newly loaded `period`;
- `wrap_pulse`=0.
REQ-021 A change of `dir` mid-period SHALL take effect only at the next wrap, `count_reset` or disabled cycle; `count_val` is never reflected mid-period.
REQ-022 A `period` or `prescale` change mid-period SHALL NOT alter the current period length.

Reset
REQ-023 While `rst_n`=0, the block SHALL asynchronously force:
- `count_val`=0, `wrap_pulse`=0, `psc_cnt`=0;
- `prd_a`=0, `psc_a`=0, `dir_a`=0.
REQ-024 Reset assertion mid-period SHALL take effect immediately, and the block SHALL restart as after REQ-023 on the first clk edge after release.

Verification
REQ-025 The bench SHALL drive `period`=4, `prescale`=0, `dir`=0, `en`=1, and SHALL check `count_val` = 0,1,2,3,4,0,1… with `wrap_pulse` high on each 0 after the first.
REQ-026 The bench SHALL drive `period`=3, `prescale`=2, `dir`=1, and SHALL check that each value holds 3 cycles, the sequence 3,2,1,0,3 repeats, and `wrap_pulse` is one cycle wide on 3.
REQ-027 The bench SHALL, in up mode at `count_val`=2 with `period`=9, write `period`=5, and SHALL check that the count reaches 9 then wraps, and the next period wraps after 5.
REQ-028 The bench SHALL drop `en` at `count_val`=6 for 10 cycles, and SHALL check that 6 is held, `wrap_pulse`=0, and counting resumes at 7 after `psc_a`+1 cycles.
REQ-029 The bench SHALL pulse `count_reset` with `dir`=1 and `period`=0x00FF mid-count, and SHALL check `count_val`=0x00FF next cycle with no `wrap_pulse`.
REQ-030 The bench SHALL assert `rst_n`=0 asynchronously between clk edges mid-count, and SHALL check that all outputs are 0 immediately and counting restarts from 0 after release.
